// File: rtl/ram_loader.sv
// ram_loader: programming front-end and sole driver of the 16x8 RAM's ADDR/DIN/RI.
//   Normal mode: CPU_ADDR/CPU_DIN/CPU_RI pass straight through (combinational mux).
//   Load mode (PROG_CSn low): bytes arrive MSB-first on PROG_SCK/PROG_SDI, are
//   written to consecutive addresses from 0, and CPU_HOLD stalls the CPU.
// Ports:
//   CLK, RESETn         system clock, async active-low reset
//   PROG_CSn/SCK/SDI    async serial link, resynchronised into CLK
//   CPU_ADDR/DIN/RI     CPU-side RAM request
//   ADDR/DIN/RI         to RAM
//   CPU_HOLD            high while the loader owns the RAM
//   LOADED              sticky: a complete DEPTH-word image was written
module ram_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              PROG_CSn,
  input  logic              PROG_SCK,
  input  logic              PROG_SDI,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  input  logic              CPU_RI,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DIN,
  output logic              RI,
  output logic              CPU_HOLD,
  output logic              LOADED
);

  localparam int BCW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, FULL} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_csn_sync, r_sck_sync, r_sdi_sync;
  logic                   r_sck_prev;
  logic [DATA_W-1:0]      r_shreg;
  logic [BCW-1:0]         r_bit_cnt;
  logic [ADDR_W-1:0]      r_addr_cnt;
  logic                   r_loaded;
  logic                   r_hold;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_din;
  logic                   r_ri;

  logic w_csn_s, w_sck_s, w_sdi_s, w_sck_rise, w_last_bit, w_last_addr, w_write_go;

  // Synchronisers idle high so reset looks like "no session, SCK high".
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_csn_sync <= '1;
      r_sck_sync <= '1;
      r_sdi_sync <= '1;
      r_sck_prev <= 1'b1;
    end else begin
      r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], PROG_CSn};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], PROG_SCK};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], PROG_SDI};
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  // SDI taken from the same stage as SCK so both see identical delay.
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_prev;
  assign w_last_bit  = (r_bit_cnt == BCW'(DATA_W - 1));
  assign w_last_addr = (r_addr_cnt == ADDR_W'(DEPTH - 1));
  // A CSn rise seen in the same cycle as the final SCK rise cancels the write.
  assign w_write_go  = (r_state == SHIFT) & ~w_csn_s & w_sck_rise & w_last_bit;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_csn_s) w_state_nxt = SHIFT;
      SHIFT:   if (w_csn_s) w_state_nxt = IDLE;
               else if (w_write_go) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = w_last_addr ? FULL : SHIFT;
      FULL:    if (w_csn_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_addr_cnt <= '0;
      r_loaded   <= 1'b0;
      r_hold     <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_ri       <= 1'b0;
    end else begin
      r_ri   <= 1'b0;
      // Rise on the transition out of IDLE, fall one cycle after re-entering it.
      r_hold <= (w_state_nxt != IDLE) | (r_state != IDLE);
      case (r_state)
        IDLE: if (!w_csn_s) begin
          r_addr_cnt <= '0;
          r_bit_cnt  <= '0;
          r_loaded   <= 1'b0;
        end
        SHIFT: if (!w_csn_s && w_sck_rise) begin
          r_shreg <= {r_shreg[DATA_W-2:0], w_sdi_s};
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            r_ri      <= 1'b1;
            r_addr    <= r_addr_cnt;
            r_din     <= {r_shreg[DATA_W-2:0], w_sdi_s};
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        WRITE: begin
          r_addr_cnt <= r_addr_cnt + 1'b1;
          if (w_last_addr) r_loaded <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only combinational path: CPU pass-through while IDLE (including during reset).
  assign ADDR     = (r_state == IDLE) ? CPU_ADDR : r_addr;
  assign DIN      = (r_state == IDLE) ? CPU_DIN  : r_din;
  assign RI       = (r_state == IDLE) ? CPU_RI   : r_ri;
  assign CPU_HOLD = r_hold;
  assign LOADED   = r_loaded;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
  localparam int SS   = 2;
  localparam int HALF = SS + 3;

  logic       clk = 1'b0;
  logic       rst_n, csn, sck, sdi;
  logic [3:0] cpu_addr, addr;
  logic [7:0] cpu_din, din;
  logic       cpu_ri, ri, hold, loaded;

  ram_loader #(.SYNC_STAGES(SS), .ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .CLK(clk), .RESETn(rst_n), .PROG_CSn(csn), .PROG_SCK(sck), .PROG_SDI(sdi),
    .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din), .CPU_RI(cpu_ri),
    .ADDR(addr), .DIN(din), .RI(ri), .CPU_HOLD(hold), .LOADED(loaded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_w;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model of a load session
  int         m_addr;
  int         m_bits;
  logic [7:0] m_byte;
  logic [7:0] exp_ram [16];
  logic [7:0] ram [16];

  initial for (int i = 0; i < 16; i++) begin ram[i] = 8'h00; exp_ram[i] = 8'h00; end

  // Behavioural RAM fed by the DUT
  always @(posedge clk) if (ri === 1'b1) ram[addr] <= din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every loader write (RI with CPU held) must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ri === 1'b1 && hold === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got addr %0h din %0h expected none", addr, din);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(mon_w.a));
        chk("wr_din",  32'(din),  32'(mon_w.d));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    int n;
    csn = 1'b0;
    m_addr = 0; m_bits = 0;
    n = 0;
    do begin wait_clk(1); n++; end while (hold !== 1'b1 && n < 20);
    chk("hold_rise", 32'(n), 32'(SS + 1));
    wait_clk(HALF);
    chk("loaded_clr", 32'(loaded), 32'd0);
  endtask

  task automatic measure_fall();
    int n;
    n = 0;
    do begin wait_clk(1); n++; end while (hold !== 1'b0 && n < 20);
    chk("hold_fall", 32'(n), 32'(SS + 2));
    wait_clk(HALF);
  endtask

  task automatic end_session();
    csn = 1'b1;
    measure_fall();
  endtask

  task automatic model_bit(input logic b);
    m_byte = {m_byte[6:0], b};
    m_bits++;
    if (m_bits == 8) begin
      m_bits = 0;
      if (m_addr < 16) begin
        exp_q.push_back('{a: 4'(m_addr), d: m_byte});
        exp_ram[m_addr] = m_byte;
        m_addr++;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    sdi = b; sck = 1'b0;
    wait_clk(HALF);
    sck = 1'b1;
    model_bit(b);
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic ram_check();
    for (int i = 0; i < 16; i++) chk("ram_readback", 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  logic [7:0] rb;
  logic [7:0] byte1;

  initial begin
    rst_n = 1'b0; csn = 1'b1; sck = 1'b1; sdi = 1'b0;
    cpu_addr = '0; cpu_din = '0; cpu_ri = 1'b0;
    wait_clk(3);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_ri", 32'(ri), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // Pass-through
    cpu_addr = 4'd5; cpu_din = 8'hA5; cpu_ri = 1'b1;
    #1;
    chk("pt_addr", 32'(addr), 32'd5);
    chk("pt_din", 32'(din), 32'hA5);
    chk("pt_ri", 32'(ri), 32'd1);
    chk("pt_hold", 32'(hold), 32'd0);
    wait_clk(1);
    cpu_ri = 1'b0;
    exp_ram[5] = 8'hA5;
    wait_clk(1);
    chk("pt_ram", 32'(ram[5]), 32'hA5);

    // Full load 0xF0..0xFF
    start_session();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("loaded_before_last", 32'(loaded), 32'd0);
      send_byte(8'hF0 + 8'(i));
    end
    chk("loaded_full", 32'(loaded), 32'd1);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);
    end_session();
    chk("loaded_sticky", 32'(loaded), 32'd1);
    ram_check();

    // Abort: one byte, 5 bits, then CSn rises
    start_session();
    send_byte(8'h3C);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    end_session();
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
    chk("abort_loaded", 32'(loaded), 32'd0);
    chk("abort_ram0", 32'(ram[0]), 32'h3C);
    cpu_addr = 4'hB; cpu_din = 8'h77;
    #1;
    chk("abort_idle_addr", 32'(addr), 32'hB);
    chk("abort_idle_din", 32'(din), 32'h77);

    // CSn rise coinciding with the 8th SCK rise: no write
    start_session();
    rb = 8'($urandom);
    send_byte(rb);
    rb = 8'($urandom);
    for (int i = 7; i >= 1; i--) send_bit(rb[i]);
    sdi = rb[0]; sck = 1'b0;
    wait_clk(HALF);
    sck = 1'b1; csn = 1'b1;
    m_bits = 0;
    measure_fall();
    chk("coinc_q_empty", 32'(exp_q.size()), 32'd0);
    ram_check();

    // Overrun: 17 random bytes
    start_session();
    byte1 = 8'($urandom);
    send_byte(byte1);
    for (int i = 1; i < 17; i++) send_byte(8'($urandom));
    chk("ovr_loaded", 32'(loaded), 32'd1);
    chk("ovr_q_empty", 32'(exp_q.size()), 32'd0);
    end_session();
    chk("ovr_ram0", 32'(ram[0]), 32'(byte1));
    ram_check();

    // Reset mid-load after 3 bytes
    start_session();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    chk("rml_q_empty", 32'(exp_q.size()), 32'd0);
    cpu_addr = 4'h9; cpu_din = 8'h5A; cpu_ri = 1'b1; rst_n = 1'b0;
    #1;
    chk("rml_ri", 32'(ri), 32'd1);
    chk("rml_addr", 32'(addr), 32'h9);
    chk("rml_din", 32'(din), 32'h5A);
    chk("rml_hold", 32'(hold), 32'd0);
    chk("rml_loaded", 32'(loaded), 32'd0);
    #1 cpu_ri = 1'b0;
    csn = 1'b1; sck = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    start_session();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    chk("rml_new_q_empty", 32'(exp_q.size()), 32'd0);
    end_session();
    ram_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
